seven_seg_scan_ctrl: RTL and testbench

Time-multiplexed scan controller for a common-anode multi-digit 7-segment display. It takes a packed hex value, decodes one nibble per scan slot, and drives the shared segment bus while enabling one digit anode at a time. Each slot starts with an anti-ghosting blank interval. New values are applied only at frame boundaries, so the display never tears. It sits between the adder/result datapath and the board display pins.

---
 rtl/seven_seg_scan_ctrl.sv | 136 +++++++++++++
 tb/tb_seven_seg_scan_ctrl.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/seven_seg_scan_ctrl.sv
// Time-multiplexed scan controller for a common-anode 7-segment display.
// Each digit slot opens with an all-off blank interval; new values are applied only at frame ends.
module seven_seg_scan_ctrl #(
    parameter int unsigned NUM_DIGITS   = 4,
    parameter int unsigned REFRESH_DIV  = 100000,
    parameter int unsigned BLANK_CYCLES = 2000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic                    load,
    input  logic [NUM_DIGITS-1:0]   dp_mask,
    input  logic                    lz_en,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic                    frame_done
);

    localparam int unsigned CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int unsigned IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] CNT_SHOW = CW'(BLANK_CYCLES);
    localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

    logic [CW-1:0]           cnt_q, cnt_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0] disp_q, disp_d;
    logic [4*NUM_DIGITS-1:0] pend_q, pend_d;
    logic                    pend_valid_q, pend_valid_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic [6:0]              seg_q, seg_d;
    logic                    dp_q, dp_d;
    logic                    frame_done_q;

    logic                    slot_end;
    logic                    boundary;
    logic                    suppress;
    logic                    show;
    logic [4*NUM_DIGITS-1:0] shifted;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    always_comb begin
        slot_end = (cnt_q == CNT_LAST);
        boundary = slot_end && (idx_q == IDX_LAST);

        cnt_d = slot_end ? '0 : cnt_q + 1'b1;
        idx_d = idx_q;
        if (slot_end) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end

        disp_d       = disp_q;
        pend_d       = pend_q;
        pend_valid_d = pend_valid_q;
        if (boundary) begin
            // A load on the boundary itself bypasses pend and lands in the next frame.
            if (load) begin
                disp_d       = value;
                pend_valid_d = 1'b0;
            end else if (pend_valid_q) begin
                disp_d       = pend_q;
                pend_valid_d = 1'b0;
            end
        end else if (load) begin
            pend_d       = value;
            pend_valid_d = 1'b1;
        end

        // Current digit's nibble sits at the bottom; all-zero means every higher nibble is zero.
        shifted  = disp_q >> {idx_q, 2'b00};
        suppress = lz_en && (idx_q != '0) && (shifted == '0);
        show     = (cnt_q >= CNT_SHOW) && !suppress;

        an_d  = '1;
        seg_d = 7'h7F;
        dp_d  = 1'b1;
        if (show) begin
            an_d[idx_q] = 1'b0;
            seg_d       = hex_to_seg(shifted[3:0]);
            dp_d        = ~dp_mask[idx_q];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q        <= '0;
            idx_q        <= '0;
            disp_q       <= '0;
            pend_q       <= '0;
            pend_valid_q <= 1'b0;
            an_q         <= '1;
            seg_q        <= 7'h7F;
            dp_q         <= 1'b1;
            frame_done_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            disp_q       <= disp_d;
            pend_q       <= pend_d;
            pend_valid_q <= pend_valid_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            frame_done_q <= boundary;
        end
    end

    assign an         = an_q;
    assign seg        = seg_q;
    assign dp         = dp_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Bench for seven_seg_scan_ctrl: directed scenarios plus random traffic, checked each cycle
// against a slot-arithmetic reference model.
module tb_seven_seg_scan_ctrl;

    localparam int N = 4;
    localparam int R = 8;
    localparam int B = 2;

    localparam logic [6:0] SEG_LUT [0:15] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load = 1'b0;
    logic        lz_en = 1'b0;
    logic [15:0] value = '0;
    logic [3:0]  dp_mask = '0;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_done;

    int total = 0;
    int bad = 0;

    // Reference state: m_t is the cycle position within the frame.
    int          m_t = 0;
    logic [15:0] m_disp = '0;
    logic [15:0] m_pend = '0;
    bit          m_pv = 1'b0;
    logic [3:0]  e_an;
    logic [6:0]  e_seg;
    logic        e_dp;
    logic        e_fd;

    seven_seg_scan_ctrl #(
        .NUM_DIGITS  (N),
        .REFRESH_DIV (R),
        .BLANK_CYCLES(B)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .value     (value),
        .load      (load),
        .dp_mask   (dp_mask),
        .lz_en     (lz_en),
        .an        (an),
        .seg       (seg),
        .dp        (dp),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One clock: predict outputs from pre-edge state and inputs, advance the model, compare.
    task automatic cyc(input bit r, input bit ld, input logic [15:0] v);
        int         slot_pos;
        int         digit;
        bit         sup;
        logic [3:0] nib;
        rst   = r;
        load  = ld;
        value = v;
        if (r) begin
            e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1; e_fd = 1'b0;
            m_t = 0; m_disp = '0; m_pend = '0; m_pv = 1'b0;
        end else begin
            slot_pos = m_t % R;
            digit    = m_t / R;
            nib      = 4'(m_disp >> (4 * digit));
            sup      = lz_en && digit > 0 && (m_disp >> (4 * digit)) == 0;
            e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
            if (slot_pos >= B && !sup) begin
                e_an  = ~(4'b0001 << digit);
                e_seg = SEG_LUT[nib];
                e_dp  = ~dp_mask[digit];
            end
            e_fd = (m_t == R * N - 1);
            if (e_fd) begin
                if (ld) begin
                    m_disp = v; m_pv = 1'b0;
                end else if (m_pv) begin
                    m_disp = m_pend; m_pv = 1'b0;
                end
            end else if (ld) begin
                m_pend = v; m_pv = 1'b1;
            end
            m_t = (m_t + 1) % (R * N);
        end
        @(posedge clk);
        #1;
        check("an", an, e_an);
        check("seg", seg, e_seg);
        check("dp", dp, e_dp);
        check("frame_done", frame_done, e_fd);
        check("an_onehot", ($countones(~an) <= 1), 1);
        rst  = 1'b0;
        load = 1'b0;
    endtask

    task automatic wait_fd();
        bit ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            cyc(1'b0, 1'b0, value);
            if (frame_done === 1'b1) ok = 1'b1;
        end
        check("wait_frame_done", ok, 1);
    endtask

    task automatic wait_show(input int d);
        bit         ok = 1'b0;
        logic [3:0] pat;
        pat = ~(4'b0001 << d);
        for (int i = 0; i < 40 && !ok; i++) begin
            cyc(1'b0, 1'b0, value);
            if (an === pat) ok = 1'b1;
        end
        check($sformatf("wait_show%0d", d), ok, 1);
    endtask

    initial begin
        // Reset, then blank-then-show timing for digit 0 and the frame pulse.
        cyc(1'b1, 1'b0, 16'h0);
        cyc(1'b1, 1'b0, 16'h0);
        check("rst_an", an, 4'hF);
        check("rst_seg", seg, 7'h7F);
        check("rst_fd", frame_done, 0);
        cyc(1'b0, 1'b0, 16'h0);
        check("blank0_an", an, 4'hF);
        cyc(1'b0, 1'b0, 16'h0);
        check("blank1_an", an, 4'hF);
        cyc(1'b0, 1'b0, 16'h0);
        check("show0_an", an, 4'b1110);
        check("show0_seg", seg, 7'b1000000);
        for (int i = 0; i < 28; i++) cyc(1'b0, 1'b0, 16'h0);
        cyc(1'b0, 1'b0, 16'h0);
        check("fd_at_32", frame_done, 1);
        cyc(1'b0, 1'b0, 16'h0);
        check("fd_one_cycle", frame_done, 0);

        // Mid-frame load is held until the next frame.
        wait_fd();
        for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, 16'h0);
        cyc(1'b0, 1'b1, 16'h3A5F);
        wait_show(0);
        check("old_frame_seg", seg, 7'b1000000);
        wait_fd();
        wait_show(0);
        check("new_d0", seg, 7'b0001110);
        wait_show(1);
        check("new_d1", seg, 7'b0010010);
        wait_show(2);
        check("new_d2", seg, 7'b0001000);
        wait_show(3);
        check("new_d3", seg, 7'b0110000);

        // Last load wins; a boundary-cycle load takes effect in the very next frame.
        wait_fd();
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 16'h0);
        cyc(1'b0, 1'b1, 16'h1111);
        for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, 16'h0);
        cyc(1'b0, 1'b1, 16'h2222);
        wait_fd();
        wait_show(0);
        check("last_wins_d0", seg, 7'b0100100);
        wait_show(3);
        check("last_wins_d3", seg, 7'b0100100);
        for (int i = 0; i < 40 && m_t != R * N - 1; i++) cyc(1'b0, 1'b0, 16'h0);
        cyc(1'b0, 1'b1, 16'hBEEF);
        check("boundary_fd", frame_done, 1);
        wait_show(0);
        check("boundary_d0", seg, 7'b0001110);
        wait_show(3);
        check("boundary_d3", seg, 7'b0000011);

        // Leading-zero suppression with dp masked on suppressed digits.
        lz_en   = 1'b1;
        dp_mask = 4'b1100;
        cyc(1'b0, 1'b1, 16'h0042);
        wait_fd();
        for (int i = 0; i < 32; i++) begin
            cyc(1'b0, 1'b0, 16'h0);
            check("lz_hi_off", an[3:2], 2'b11);
            check("lz_dp_off", dp, 1);
        end
        wait_show(0);
        check("lz_d0", seg, 7'b0100100);
        wait_show(1);
        check("lz_d1", seg, 7'b0011001);
        cyc(1'b0, 1'b1, 16'h0000);
        wait_fd();
        for (int i = 0; i < 32; i++) begin
            cyc(1'b0, 1'b0, 16'h0);
            check("lz_zero_off", an[3:1], 3'b111);
        end
        wait_show(0);
        check("lz_zero_d0", seg, 7'b1000000);

        // Decimal points only during SHOW of masked digits.
        lz_en   = 1'b0;
        dp_mask = 4'b0101;
        wait_show(2);
        check("dp_d2_on", dp, 0);
        wait_show(3);
        check("dp_d3_off", dp, 1);
        for (int i = 0; i < 64; i++) cyc(1'b0, 1'b0, 16'h0);

        // Reset mid-SHOW of digit 2 with a pending load discards it.
        dp_mask = 4'b0000;
        cyc(1'b0, 1'b1, 16'h1234);
        wait_fd();
        wait_show(2);
        cyc(1'b0, 1'b1, 16'h7777);
        cyc(1'b1, 1'b0, 16'h0);
        check("mid_rst_an", an, 4'hF);
        check("mid_rst_seg", seg, 7'h7F);
        check("mid_rst_fd", frame_done, 0);
        wait_show(0);
        check("after_rst_d0", seg, 7'b1000000);
        wait_fd();
        wait_show(3);
        check("pend_dropped_d3", seg, 7'b1000000);

        // Random traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            logic [15:0] v;
            logic [15:0] msk;
            case ($urandom_range(0, 3))
                0: msk = 16'hFFFF;
                1: msk = 16'h00FF;
                2: msk = 16'h000F;
                default: msk = 16'h0000;
            endcase
            v = 16'($urandom) & msk;
            if ($urandom_range(0, 31) == 0) lz_en = 1'($urandom);
            if ($urandom_range(0, 31) == 0) dp_mask = 4'($urandom);
            cyc(($urandom_range(0, 199) == 0), ($urandom_range(0, 7) == 0), v);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
